// File: rtl/point_bounds_tracker_if.sv
// Pixel stream from the colour-match front end into a bounds tracker.
// master drives frame_start/pix_valid/hcount/vcount/pix_hit; slave receives.
interface point_bounds_tracker_if;
  logic        frame_start;
  logic        pix_valid;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        pix_hit;

  modport master (
    output frame_start,
    output pix_valid,
    output hcount,
    output vcount,
    output pix_hit
  );

  modport slave (
    input frame_start,
    input pix_valid,
    input hcount,
    input vcount,
    input pix_hit
  );
endinterface

// File: rtl/point_bounds_tracker.sv
// Per-frame min/max X/Y of matching pixels; publishes {min,max} at frame_start.
// Ports: clk, reset_n, pix (stream slave), hor, vert, found, bounds_valid.
module point_bounds_tracker #(
  parameter int H_ACTIVE = 1024,
  parameter int V_ACTIVE = 768,
  parameter int MIN_HITS = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  point_bounds_tracker_if.slave        pix,
  output logic [21:0]                  hor,
  output logic [21:0]                  vert,
  output logic                         found,
  output logic                         bounds_valid
);

  localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
  localparam logic [10:0] V_LIM = 11'(V_ACTIVE);
  localparam logic [19:0] H_MIN = 20'(MIN_HITS);
  localparam logic [19:0] H_SAT = 20'hFFFFF;

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  state_t      state;
  logic [10:0] min_x;
  logic [10:0] max_x;
  logic [10:0] min_y;
  logic [10:0] max_y;
  logic [19:0] hits;
  logic        qual;

  assign qual = pix.pix_valid & pix.pix_hit &
                (pix.hcount < H_LIM) &
                (pix.vcount < V_LIM);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      hor          <= '0;
      vert         <= '0;
      found        <= 1'b0;
      bounds_valid <= 1'b0;
      min_x        <= 11'h7FF;
      max_x        <= '0;
      min_y        <= 11'h7FF;
      max_y        <= '0;
      hits         <= '0;
    end else begin
      bounds_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pix.frame_start)
            state <= ACCUM;
        end
        ACCUM: begin
          if (pix.frame_start) begin
            bounds_valid <= 1'b1;
            if (hits >= H_MIN) begin
              hor   <= {min_x, max_x};
              vert  <= {min_y, max_y};
              found <= 1'b1;
            end else begin
              found <= 1'b0;
            end
            // A pixel coinciding with frame_start opens the new frame.
            min_x <= qual ? pix.hcount : 11'h7FF;
            max_x <= qual ? pix.hcount : 11'h000;
            min_y <= qual ? pix.vcount : 11'h7FF;
            max_y <= qual ? pix.vcount : 11'h000;
            hits  <= qual ? 20'd1 : 20'd0;
          end else if (qual) begin
            if (pix.hcount < min_x) min_x <= pix.hcount;
            if (pix.hcount > max_x) max_x <= pix.hcount;
            if (pix.vcount < min_y) min_y <= pix.vcount;
            if (pix.vcount > max_y) max_y <= pix.vcount;
            if (hits != H_SAT) hits <= hits + 20'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
